pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage LoongArch core. Drives the PC, IF/ID, ID/EX and EX/MEM stage-register controls: write enables, IF/ID refresh (bubble insert) and ID/EX flush. It covers boot hold-off, load-use interlock, taken-branch redirect and multi-cycle EX operations (mul/div), and keeps saturating stall/flush performance counters. It sits beside the datapath and owns every stall/flush decision; stage registers contain no hazard logic of their own.

## Interface
- BOOT_CYCLES, 1: cycles after reset release during which fetched instructions are discarded (1..15)
- MC_MAX, 64: max cycles a multi-cycle op may hold EX before timeout
- CNT_W, 32: perf counter width
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rj, id_rk  in  5  source registers of instruction in ID
- id_use_rj, id_use_rk  in  1  ID instruction actually reads rj/rk
- ex_rd  in  5  destination of instruction in EX
- ex_wen  in  1  EX instruction writes GR
- ex_is_load  in  1  EX instruction is ld.*
- ex_br_taken  in  1  branch/jump in EX resolved taken
- ex_br_target  in  32  redirect address
- ex_mc_start  in  1  multi-cycle op entered EX this cycle
- mc_done  in  1  multi-cycle unit result valid
- pc_we  out  1  PC register update
- pc_redirect  out  1  select ex_br_target as next PC
- pc_target  out  32  redirect address (ex_br_target passthrough when pc_redirect, else 0)
- ifid_we  out  1  IF/ID write enable
- ifid_fresh  out  1  IF/ID load nop (inst=0)
- idex_we  out  1  ID/EX write enable
- idex_flush  out  1  ID/EX load bubble
- exmem_bubble  out  1  EX/MEM load bubble
- mc_err  out  1  sticky: multi-cycle timeout occurred
- stall_cnt, flush_cnt  out  CNT_W  saturating perf counters

## Operation
- States: BOOT, RUN, MC_WAIT. Reset → BOOT, boot counter = BOOT_CYCLES-1, counters 0, mc_err 0.
- BOOT: pc_we=1, ifid_fresh=1, idex_flush=1, idex_we=1, all other controls 0; when boot counter reaches 0 → RUN next cycle.
- RUN events, priority high→low:
  1. ex_br_taken: pc_we=1, pc_redirect=1, ifid_fresh=1, idex_flush=1; flush_cnt+1. Overrides a simultaneous load-use hazard.
  2. ex_mc_start && !mc_done: pc_we=0, ifid_we=0, idex_we=0, exmem_bubble=1; → MC_WAIT, timeout counter cleared; stall_cnt+1.
  3. Load-use: ex_is_load & ex_wen & ex_rd≠0 & ((id_use_rj & id_rj==ex_rd) | (id_use_rk & id_rk==ex_rd)): pc_we=0, ifid_we=0, idex_flush=1; stall_cnt+1. Exactly one bubble; the hazard clears as the load advances.
  4. Otherwise: pc_we=ifid_we=idex_we=1, all flush/bubble controls 0.
- ex_mc_start with mc_done in the same cycle is a single-cycle op: no stall.
- MC_WAIT: hold as in event 2 each cycle, stall_cnt+1. On mc_done: all enables 1, no bubble → RUN. ex_br_taken, ex_mc_start and load-use are ignored (EX is occupied). If the timeout counter reaches MC_MAX-1 without mc_done: behave as mc_done, set mc_err → RUN.
- Counters saturate at all-ones; never wrap.
- ex_rd==0 never produces a hazard (r0 hardwired).

## Timing
- All outputs are combinational from current state plus inputs (Mealy). Stage registers sample them at the same edge.
- Branch penalty: 2 bubbles (IF/ID, ID/EX); target fetched the cycle after ex_br_taken.
- Load-use: 1 bubble cycle.
- Multi-cycle op of N cycles (mc_done in cycle N after start): N-1 stall cycles, 0 if N=1.
- Asynchronous reset assertion mid-MC_WAIT or mid-BOOT forces BOOT immediately; outputs take BOOT values while rst_n is low. Deassertion is synchronised externally.

## Structure
- Shared package pipe_pkg: state enum (BOOT, RUN, MC_WAIT), R0 constant, LA_INST_W=32.
- Sub-module hazard_detect (combinational load-use compare) instantiated once; FSM, timeout counter and perf counters live in the top.

## Test plan
- Reset with BOOT_CYCLES=1: rst_n low→high → one cycle ifid_fresh=1, pc_we=1, then RUN with ifid_we=1; counters 0.
- Load-use: ex_is_load=1, ex_wen=1, ex_rd=5, id_rj=5, id_use_rj=1 for one cycle → pc_we=0, ifid_we=0, idex_flush=1; stall_cnt=1. Repeat with ex_rd=0 → no stall.
- Branch + simultaneous load-use: ex_br_taken=1, target 0x1c000100 → pc_redirect=1, pc_target=0x1c000100, ifid_fresh=idex_flush=1; flush_cnt=1, stall_cnt unchanged.
- Div of 5 cycles: ex_mc_start at t0, mc_done at t4 → exmem_bubble=1 at t0..t3, enables 1 at t4, stall_cnt=4; ex_br_taken pulsed at t2 ignored.
- Timeout, MC_MAX=8: ex_mc_start, no mc_done → RUN after 8 stall cycles, mc_err=1 and sticky until reset.
- CNT_W=4: hold load-use 20 cycles → stall_cnt saturates at 15; rst_n pulse mid-MC_WAIT → BOOT, counters 0, mc_err 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

    // Controller states: boot hold-off, normal issue, multi-cycle EX wait
    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        MC_WAIT = 2'd2
    } state_e;

    // r0 is hardwired to zero and never carries a dependency
    localparam logic [4:0] R0 = 5'd0;

    // Instruction and address width of the core
    localparam int LA_INST_W = 32;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use dependency compare
//
// Ports:
//   ex_is_load_i, ex_wen_i, ex_rd_i   : load in EX and its destination
//   id_rj_i, id_rk_i                  : sources of the instruction in ID
//   id_use_rj_i, id_use_rk_i          : ID instruction really reads rj/rk
//   hazard_o                          : ID must wait one cycle for the load data
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       ex_is_load_i,
    input  logic       ex_wen_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rj_i,
    input  logic [4:0] id_rk_i,
    input  logic       id_use_rj_i,
    input  logic       id_use_rk_i,
    output logic       hazard_o
);

    logic rj_match;
    logic rk_match;

    assign rj_match = id_use_rj_i && (id_rj_i == ex_rd_i);
    assign rk_match = id_use_rk_i && (id_rk_i == ex_rd_i);

    // A write to r0 is discarded, so it can never feed a later reader
    assign hazard_o = ex_is_load_i && ex_wen_i && (ex_rd_i != R0) && (rj_match || rk_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencing for the 5-stage pipeline
//
// Ports:
//   clk, rst_n                        : core clock, async active-low reset
//   id_*, ex_rd/ex_wen/ex_is_load     : operand/destination info for load-use
//   ex_br_taken, ex_br_target         : taken branch resolved in EX
//   ex_mc_start, mc_done              : multi-cycle EX op handshake
//   pc_we, pc_redirect, pc_target     : PC register controls
//   ifid_we, ifid_fresh               : IF/ID write enable / load nop
//   idex_we, idex_flush               : ID/EX write enable / load bubble
//   exmem_bubble                      : EX/MEM load bubble
//   mc_err                            : sticky multi-cycle timeout flag
//   stall_cnt, flush_cnt              : saturating performance counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BOOT_CYCLES = 1,
    parameter int MC_MAX      = 64,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           id_rj,
    input  logic [4:0]           id_rk,
    input  logic                 id_use_rj,
    input  logic                 id_use_rk,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_wen,
    input  logic                 ex_is_load,
    input  logic                 ex_br_taken,
    input  logic [LA_INST_W-1:0] ex_br_target,
    input  logic                 ex_mc_start,
    input  logic                 mc_done,
    output logic                 pc_we,
    output logic                 pc_redirect,
    output logic [LA_INST_W-1:0] pc_target,
    output logic                 ifid_we,
    output logic                 ifid_fresh,
    output logic                 idex_we,
    output logic                 idex_flush,
    output logic                 exmem_bubble,
    output logic                 mc_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int          TW        = (MC_MAX > 2) ? $clog2(MC_MAX) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(MC_MAX - 1);
    localparam logic [3:0]  BOOT_INIT = 4'(BOOT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       boot_q, boot_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             stall_inc;
    logic             flush_inc;
    logic             lu_hazard;

    hazard_detect u_hazard_detect (
        .ex_is_load_i (ex_is_load),
        .ex_wen_i     (ex_wen),
        .ex_rd_i      (ex_rd),
        .id_rj_i      (id_rj),
        .id_rk_i      (id_rk),
        .id_use_rj_i  (id_use_rj),
        .id_use_rk_i  (id_use_rk),
        .hazard_o     (lu_hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            boot_q  <= BOOT_INIT;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        boot_d       = boot_q;
        tcnt_d       = tcnt_q;
        err_d        = err_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        pc_we        = 1'b0;
        pc_redirect  = 1'b0;
        ifid_we      = 1'b0;
        ifid_fresh   = 1'b0;
        idex_we      = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;

        case (state_q)
            BOOT: begin
                // Keep fetching but discard everything until the front end settles
                pc_we      = 1'b1;
                ifid_fresh = 1'b1;
                idex_we    = 1'b1;
                idex_flush = 1'b1;
                if (boot_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    boot_d = boot_q - 4'd1;
                end
            end

            RUN: begin
                if (ex_br_taken) begin
                    // Squash the two younger instructions in IF/ID and ID/EX
                    pc_we       = 1'b1;
                    pc_redirect = 1'b1;
                    ifid_fresh  = 1'b1;
                    idex_we     = 1'b1;
                    idex_flush  = 1'b1;
                    flush_inc   = 1'b1;
                end else if (ex_mc_start && !mc_done) begin
                    exmem_bubble = 1'b1;
                    state_d      = MC_WAIT;
                    tcnt_d       = '0;
                    stall_inc    = 1'b1;
                end else if (lu_hazard) begin
                    // Hold IF and ID, push one bubble into EX
                    idex_we    = 1'b1;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                end
            end

            MC_WAIT: begin
                // EX is busy: branch, new mc start and load-use are not looked at
                if (mc_done || (tcnt_q == TO_LAST)) begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                    state_d = RUN;
                    if (!mc_done) begin
                        err_d = 1'b1;
                    end
                end else begin
                    exmem_bubble = 1'b1;
                    tcnt_d       = tcnt_q + 1'b1;
                    stall_inc    = 1'b1;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Counters stick at all-ones instead of wrapping
    assign stall_d = (stall_inc && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    assign flush_d = (flush_inc && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;

    assign pc_target = pc_redirect ? ex_br_target : '0;
    assign mc_err    = err_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic        rst;
        logic        br;
        logic [31:0] tgt;
        logic        mcs;
        logic        mcd;
        logic        ld;
        logic        wen;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic        urj;
        logic        urk;
    } in_t;

    typedef struct packed {
        logic          pc_we;
        logic          pc_redirect;
        logic [31:0]   pc_target;
        logic          ifid_we;
        logic          ifid_fresh;
        logic          idex_we;
        logic          idex_flush;
        logic          exmem_bubble;
        logic          mc_err;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rj, id_rk, ex_rd;
    logic        id_use_rj, id_use_rk, ex_wen, ex_is_load, ex_br_taken;
    logic [31:0] ex_br_target;
    logic        ex_mc_start, mc_done;
    logic        pc_we, pc_redirect, ifid_we, ifid_fresh, idex_we, idex_flush;
    logic        exmem_bubble, mc_err;
    logic [31:0] pc_target;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t tbl[$];
    vec_t sb_q[$];
    out_t act;

    pipe_hazard_ctrl #(
        .BOOT_CYCLES (1),
        .MC_MAX      (8),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rj        (id_rj),
        .id_rk        (id_rk),
        .id_use_rj    (id_use_rj),
        .id_use_rk    (id_use_rk),
        .ex_rd        (ex_rd),
        .ex_wen       (ex_wen),
        .ex_is_load   (ex_is_load),
        .ex_br_taken  (ex_br_taken),
        .ex_br_target (ex_br_target),
        .ex_mc_start  (ex_mc_start),
        .mc_done      (mc_done),
        .pc_we        (pc_we),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .ifid_we      (ifid_we),
        .ifid_fresh   (ifid_fresh),
        .idex_we      (idex_we),
        .idex_flush   (idex_flush),
        .exmem_bubble (exmem_bubble),
        .mc_err       (mc_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        act = '{pc_we, pc_redirect, pc_target, ifid_we, ifid_fresh, idex_we,
                idex_flush, exmem_bubble, mc_err, stall_cnt, flush_cnt};
    end

    // Scoreboard: pop one expectation per cycle, mid-cycle, away from the edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            vec_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got=%h want=%h", e.name, act, e.exp);
            end
        end
    end

    function automatic in_t i_idle();
        in_t i;
        i = '0;
        i.rst = 1'b1;
        return i;
    endfunction

    function automatic in_t i_lu(logic [4:0] rd, logic [4:0] rj, logic [4:0] rk,
                                 logic urj, logic urk);
        in_t i;
        i = i_idle();
        i.ld  = 1'b1;
        i.wen = 1'b1;
        i.rd  = rd;
        i.rj  = rj;
        i.rk  = rk;
        i.urj = urj;
        i.urk = urk;
        return i;
    endfunction

    function automatic out_t o_boot(int s, int f, logic e);
        out_t o;
        o = '0;
        o.pc_we = 1'b1; o.ifid_fresh = 1'b1; o.idex_we = 1'b1; o.idex_flush = 1'b1;
        o.stall = CW'(s); o.flush = CW'(f); o.mc_err = e;
        return o;
    endfunction

    function automatic out_t o_run(int s, int f, logic e);
        out_t o;
        o = '0;
        o.pc_we = 1'b1; o.ifid_we = 1'b1; o.idex_we = 1'b1;
        o.stall = CW'(s); o.flush = CW'(f); o.mc_err = e;
        return o;
    endfunction

    function automatic out_t o_lu(int s, int f, logic e);
        out_t o;
        o = '0;
        o.idex_we = 1'b1; o.idex_flush = 1'b1;
        o.stall = CW'(s); o.flush = CW'(f); o.mc_err = e;
        return o;
    endfunction

    function automatic out_t o_br(logic [31:0] t, int s, int f, logic e);
        out_t o;
        o = '0;
        o.pc_we = 1'b1; o.pc_redirect = 1'b1; o.pc_target = t;
        o.ifid_fresh = 1'b1; o.idex_we = 1'b1; o.idex_flush = 1'b1;
        o.stall = CW'(s); o.flush = CW'(f); o.mc_err = e;
        return o;
    endfunction

    function automatic out_t o_mc(int s, int f, logic e);
        out_t o;
        o = '0;
        o.exmem_bubble = 1'b1;
        o.stall = CW'(s); o.flush = CW'(f); o.mc_err = e;
        return o;
    endfunction

    // Drive one cycle of inputs (just after the edge) and queue its expectation
    task automatic apply(string name, in_t i, out_t o);
        vec_t v;
        rst_n        = i.rst;
        ex_br_taken  = i.br;
        ex_br_target = i.tgt;
        ex_mc_start  = i.mcs;
        mc_done      = i.mcd;
        ex_is_load   = i.ld;
        ex_wen       = i.wen;
        ex_rd        = i.rd;
        id_rj        = i.rj;
        id_rk        = i.rk;
        id_use_rj    = i.urj;
        id_use_rk    = i.urk;
        v.name = name;
        v.in   = i;
        v.exp  = o;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic add(string name, in_t i, out_t o);
        vec_t v;
        v.name = name;
        v.in   = i;
        v.exp  = o;
        tbl.push_back(v);
    endtask

    initial begin
        in_t i;
        int  s;

        rst_n = 1'b0;
        {ex_br_taken, ex_br_target, ex_mc_start, mc_done, ex_is_load, ex_wen} = '0;
        {ex_rd, id_rj, id_rk, id_use_rj, id_use_rk} = '0;

        i = i_idle(); i.rst = 1'b0;
        add("reset_hold", i, o_boot(0, 0, 0));
        add("boot_cycle", i_idle(), o_boot(0, 0, 0));
        add("run_idle", i_idle(), o_run(0, 0, 0));
        add("lu_rj", i_lu(5'd5, 5'd5, 5'd0, 1, 0), o_lu(0, 0, 0));
        add("after_lu", i_idle(), o_run(1, 0, 0));
        add("lu_rk", i_lu(5'd7, 5'd3, 5'd7, 0, 1), o_lu(1, 0, 0));
        add("lu_r0", i_lu(5'd0, 5'd0, 5'd0, 1, 1), o_run(2, 0, 0));
        add("lu_nouse", i_lu(5'd5, 5'd5, 5'd5, 0, 0), o_run(2, 0, 0));
        i = i_lu(5'd5, 5'd5, 5'd0, 1, 0); i.wen = 1'b0;
        add("lu_nowen", i, o_run(2, 0, 0));
        i = i_lu(5'd5, 5'd5, 5'd0, 1, 0); i.br = 1'b1; i.tgt = 32'h1c00_0100;
        add("br_over_lu", i, o_br(32'h1c00_0100, 2, 0, 0));
        add("after_br", i_idle(), o_run(2, 1, 0));
        i = i_idle(); i.mcs = 1'b1; i.mcd = 1'b1;
        add("mc_single", i, o_run(2, 1, 0));
        i = i_idle(); i.mcs = 1'b1;
        add("div_t0", i, o_mc(2, 1, 0));
        add("div_t1", i_idle(), o_mc(3, 1, 0));
        i = i_idle(); i.br = 1'b1; i.tgt = 32'hdead_beef;
        add("div_t2_br", i, o_mc(4, 1, 0));
        i = i_lu(5'd9, 5'd9, 5'd0, 1, 0); i.mcs = 1'b1;
        add("div_t3_lu", i, o_mc(5, 1, 0));
        i = i_idle(); i.mcd = 1'b1;
        add("div_t4_done", i, o_run(6, 1, 0));
        add("div_after", i_idle(), o_run(6, 1, 0));

        @(posedge clk);
        #1;
        foreach (tbl[k]) apply(tbl[k].name, tbl[k].in, tbl[k].exp);

        // Timeout with MC_MAX=8: eight stall cycles, then release and sticky mc_err
        i = i_idle(); i.mcs = 1'b1;
        apply("to_start", i, o_mc(6, 1, 0));
        for (int k = 1; k <= 7; k++) apply("to_wait", i_idle(), o_mc(6 + k, 1, 0));
        apply("to_release", i_idle(), o_run(14, 1, 0));
        apply("to_err_set", i_idle(), o_run(14, 1, 1));
        apply("to_err_sticky", i_idle(), o_run(14, 1, 1));

        // Held load-use drives stall_cnt into saturation at 15
        for (int k = 0; k < 20; k++) begin
            s = (14 + k > 15) ? 15 : 14 + k;
            apply("lu_sat", i_lu(5'd12, 5'd0, 5'd12, 0, 1), o_lu(s, 1, 1));
        end
        apply("sat_hold", i_idle(), o_run(15, 1, 1));

        // Reset asserted in the middle of MC_WAIT
        i = i_idle(); i.mcs = 1'b1;
        apply("mc_pre_rst", i, o_mc(15, 1, 1));
        apply("mc_wait_pre_rst", i_idle(), o_mc(15, 1, 1));
        i = i_idle(); i.rst = 1'b0; i.mcd = 1'b1;
        apply("rst_mid_mc", i, o_boot(0, 0, 0));
        apply("reboot", i_idle(), o_boot(0, 0, 0));
        apply("rerun", i_idle(), o_run(0, 0, 0));

        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got=%0d pending want=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
